// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the CPU core.
// Walks fetch/decode/execute/memory/writeback around the external decoder
// and ALU, owns the PC and the retired-instruction counter. Every output is
// a register loaded from the next-state decode, so each strobe lines up with
// the state it belongs to while staying glitch-free.
module cpu_sequencer #(
  parameter int PC_W        = 8,
  parameter int IMEM_LAT    = 1,
  parameter int ALU_TIMEOUT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  output logic            ir_load,
  input  logic [5:0]      op,
  input  logic            dec_write,
  input  logic            dec_pc_ctrl,
  input  logic [PC_W-1:0] br_target,
  output logic            alu_start,
  input  logic            alu_done,
  output logic            dmem_re,
  input  logic            dmem_rvalid,
  output logic            dmem_we,
  output logic            wb_en,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
  output logic            timeout_err,
  output logic [15:0]     retired
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_DECODE   = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_ALU_WAIT = 3'd4;
  localparam logic [2:0] S_MEM      = 3'd5;
  localparam logic [2:0] S_WB       = 3'd6;
  localparam logic [2:0] S_HALT     = 3'd7;

  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_MUL  = 6'h03;
  localparam logic [5:0] OP_ADDI = 6'h04;
  localparam logic [5:0] OP_LDI  = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h06;
  localparam logic [5:0] OP_SW   = 6'h07;
  localparam logic [5:0] OP_BEQ  = 6'h08;
  localparam logic [5:0] OP_J    = 6'h09;
  localparam logic [5:0] OP_BNE  = 6'h0A;
  localparam logic [5:0] OP_MOV  = 6'h0B;
  localparam logic [5:0] OP_DIV  = 6'h3F;

  // Last FETCH cycle index and ALU wait limit, sized to their counters
  localparam logic [2:0]      FETCH_LAST = 3'(IMEM_LAT - 1);
  localparam logic [7:0]      ALU_LIMIT  = 8'(ALU_TIMEOUT);
  localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

  logic [2:0]      r_state;
  logic [2:0]      r_fcnt;
  logic [7:0]      r_acnt;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_retired;
  logic            r_terr;
  logic            r_ir_load;
  logic            r_alu_start;
  logic            r_dmem_re;
  logic            r_dmem_we;
  logic            r_wb_en;

  logic            w_is_mdiv;
  logic            w_is_alu1;
  logic            w_is_lw;
  logic            w_is_sw;
  logic            w_is_br;
  logic [2:0]      w_nxt;
  logic [2:0]      w_fcnt_nxt;
  logic [7:0]      w_acnt_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic            w_retire;
  logic            w_terr_set;

  // Opcode classes; anything outside these falls through as a NOP
  always_comb begin
    w_is_mdiv = (op == OP_MUL) || (op == OP_DIV);
    w_is_alu1 = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) ||
                (op == OP_LDI) || (op == OP_MOV);
    w_is_lw   = (op == OP_LW);
    w_is_sw   = (op == OP_SW);
    w_is_br   = (op == OP_BEQ) || (op == OP_J) || (op == OP_BNE);
  end

  // Next-state, PC and retire decision
  always_comb begin
    w_nxt      = r_state;
    w_fcnt_nxt = r_fcnt;
    w_acnt_nxt = r_acnt;
    w_pc_nxt   = r_pc;
    w_retire   = 1'b0;
    w_terr_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_nxt      = S_FETCH;
          w_fcnt_nxt = 3'd0;
        end
      end
      S_FETCH: begin
        if (r_fcnt == FETCH_LAST) w_nxt = S_DECODE;
        else                      w_fcnt_nxt = r_fcnt + 3'd1;
      end
      S_DECODE: w_nxt = S_EXEC;
      S_EXEC: begin
        if (w_is_mdiv) begin
          w_nxt      = S_ALU_WAIT;
          w_acnt_nxt = 8'd1;
        end else if (w_is_alu1 || w_is_sw) begin
          w_nxt = S_WB;
        end else if (w_is_lw) begin
          w_nxt = S_MEM;
        end else begin
          // Branches and NOPs retire straight out of EXEC
          w_pc_nxt   = (w_is_br && dec_pc_ctrl) ? br_target : r_pc + PC_ONE;
          w_retire   = 1'b1;
          w_nxt      = run ? S_FETCH : S_IDLE;
          w_fcnt_nxt = 3'd0;
        end
      end
      S_ALU_WAIT: begin
        // done wins over the timeout in the final allowed cycle
        if (alu_done) begin
          w_nxt = S_WB;
        end else if (r_acnt == ALU_LIMIT) begin
          w_nxt      = S_HALT;
          w_terr_set = 1'b1;
        end else begin
          w_acnt_nxt = r_acnt + 8'd1;
        end
      end
      S_MEM: begin
        if (dmem_rvalid) w_nxt = S_WB;
      end
      S_WB: begin
        w_pc_nxt   = r_pc + PC_ONE;
        w_retire   = 1'b1;
        w_nxt      = run ? S_FETCH : S_IDLE;
        w_fcnt_nxt = 3'd0;
      end
      S_HALT:  w_nxt = S_HALT;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State, counters, PC and strobes; strobes are loaded for the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fcnt      <= 3'd0;
      r_acnt      <= 8'd0;
      r_pc        <= '0;
      r_terr      <= 1'b0;
      r_ir_load   <= 1'b0;
      r_alu_start <= 1'b0;
      r_dmem_re   <= 1'b0;
      r_dmem_we   <= 1'b0;
      r_wb_en     <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_fcnt      <= w_fcnt_nxt;
      r_acnt      <= w_acnt_nxt;
      r_pc        <= w_pc_nxt;
      r_terr      <= r_terr | w_terr_set;
      r_ir_load   <= (w_nxt == S_FETCH) && (w_fcnt_nxt == FETCH_LAST);
      r_alu_start <= (w_nxt == S_EXEC) && (w_is_mdiv || w_is_alu1);
      r_dmem_we   <= (w_nxt == S_EXEC) && w_is_sw;
      r_dmem_re   <= ((w_nxt == S_EXEC) && w_is_lw) || (w_nxt == S_MEM);
      r_wb_en     <= (w_nxt == S_WB) && dec_write;
    end
  end

  // Retired-instruction counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst)                                   r_retired <= 16'd0;
    else if (w_retire && (r_retired != 16'hFFFF)) r_retired <= r_retired + 16'd1;
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign state       = r_state;
  assign ir_load     = r_ir_load;
  assign alu_start   = r_alu_start;
  assign dmem_re     = r_dmem_re;
  assign dmem_we     = r_dmem_we;
  assign wb_en       = r_wb_en;
  assign timeout_err = r_terr;
  assign retired     = r_retired;

endmodule
